// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding and
// the RUN-state event priority (dcache_miss > div_start > icache_miss > redirect > load-use).
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    IWAIT   = 2'd1,
    DWAIT   = 2'd2,
    DIVWAIT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_DMISS = 3'd1,
    EV_DIV   = 3'd2,
    EV_IMISS = 3'd3,
    EV_REDIR = 3'd4,
    EV_LDUSE = 3'd5
  } run_ev_t;

  function automatic run_ev_t run_event(input logic dmiss, input logic div,
                                        input logic imiss, input logic redir,
                                        input logic lduse);
    if (dmiss)      return EV_DMISS;
    else if (div)   return EV_DIV;
    else if (imiss) return EV_IMISS;
    else if (redir) return EV_REDIR;
    else if (lduse) return EV_LDUSE;
    else            return EV_NONE;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Wrapping stall-cycle and redirect-flush counters; built only with PIPE_PERF_EN.
module pipe_perf_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_flush,
  output logic [WIDTH-1:0] stall_cycles,
  output logic [WIDTH-1:0] flush_count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall)          stall_cycles <= stall_cycles + 1'b1;
      if (redirect_flush) flush_count  <= flush_count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_use_hz,
  input  logic             br_redirect_e,
  input  logic             icache_miss,
  input  logic             icache_ready,
  input  logic             dcache_miss,
  input  logic             dcache_ready,
  input  logic             div_start,
  input  logic             div_done,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             flush_fd,
  output logic             stall_de,
  output logic             flush_de,
  output logic             stall_em,
  output logic             flush_em,
  output logic             stall_mw,
  output logic [WIDTH-1:0] stall_cycles,
  output logic [WIDTH-1:0] flush_count,
  output logic [1:0]       fsm_state
);

  state_t state_q, state_d;
  logic   kill_q, kill_d;
  logic   pc, sfd, ffd, sde, fde, sem, fem, smw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    pc  = 1'b0; sfd = 1'b0; ffd = 1'b0; sde = 1'b0;
    fde = 1'b0; sem = 1'b0; fem = 1'b0; smw = 1'b0;
    case (state_q)
      RUN: begin
        case (run_event(dcache_miss, div_start, icache_miss, br_redirect_e, ld_use_hz))
          EV_DMISS: begin
            {pc, sfd, sde, sem, smw} = 5'b11111;
            state_d = DWAIT;
          end
          EV_DIV: begin
            {pc, sfd, sde, fem} = 4'b1111;
            state_d = DIVWAIT;
          end
          // A ready arriving with the miss is not consumed here: the wait lasts until the next ready.
          EV_IMISS: begin
            {pc, ffd} = 2'b11;
            state_d = IWAIT;
          end
          EV_REDIR: {ffd, fde} = 2'b11;
          EV_LDUSE: {pc, sfd, fde} = 3'b111;
          default: ;
        endcase
      end
      IWAIT: begin
        pc  = 1'b1;
        ffd = 1'b1;
        // Redirect target is loaded into PC now; the in-flight fill becomes wrong-path.
        if (br_redirect_e) begin
          pc  = 1'b0;
          fde = 1'b1;
        end
        if (icache_ready) begin
          state_d = RUN;
          kill_d  = 1'b0;
          if (!kill_q && !br_redirect_e) begin
            pc  = 1'b0;
            ffd = 1'b0;
          end
        end else if (br_redirect_e) begin
          kill_d = 1'b1;
        end
      end
      DWAIT: begin
        if (dcache_ready) state_d = RUN;
        else              {pc, sfd, sde, sem, smw} = 5'b11111;
      end
      DIVWAIT: begin
        if (div_done) state_d = RUN;
        else          {pc, sfd, sde, fem} = 4'b1111;
      end
      default: state_d = RUN;
    endcase
  end

  // Flush beats stall on the same register; everything is forced low during reset.
  assign stall_pc  = ~rst & pc;
  assign stall_fd  = ~rst & sfd & ~ffd;
  assign flush_fd  = ~rst & ffd;
  assign stall_de  = ~rst & sde & ~fde;
  assign flush_de  = ~rst & fde;
  assign stall_em  = ~rst & sem & ~fem;
  assign flush_em  = ~rst & fem;
  assign stall_mw  = ~rst & smw;
  assign fsm_state = state_q;

`ifdef PIPE_PERF_EN
  // flush_de with a redirect present is always redirect-caused (redirect outranks load-use).
  pipe_perf_cnt #(.WIDTH(WIDTH)) u_perf (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall_pc),
    .redirect_flush (flush_de & br_redirect_e),
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
